lfsr_dispatch_ctrl: RTL and testbench

- Sequences one shared 64-bit plaintext LFSR instance and distributes its output words round-robin to NUM_REQ DES cores.
- Seeds and kicks the LFSR, then grants one word per cycle to one requesting core.
- Counts delivered words and stops the LFSR once NUM_WORDS have been issued.
- Sits between the top-level command interface and the core array in the DES cryptanalysis datapath.

---
 rtl/lfsr_dispatch_ctrl_if.sv | 37 +++
 rtl/lfsr_dispatch_ctrl.sv | 130 +++++++++++++
 tb/tb_lfsr_dispatch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_dispatch_ctrl_if.sv
// Bundle between the dispatch controller, the command front end, the shared
// plaintext LFSR and the DES core array.
interface lfsr_dispatch_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
);
    // cmd_start/cmd_abort are single-cycle pulses; lfsr_valid qualifies
    // lfsr_word every cycle with no backpressure; req is a level per core and
    // gnt is a one-cycle one-hot pulse that qualifies gnt_data (0 otherwise).
    logic               cmd_start;
    logic               cmd_abort;
    logic [63:0]        cmd_seed;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   issued;
    logic               lfsr_rst_n;
    logic               lfsr_start;
    logic [63:0]        lfsr_seed;
    logic [63:0]        lfsr_word;
    logic               lfsr_valid;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [63:0]        gnt_data;
    logic [2:0]         dbg_state;

    modport master (
        input  cmd_start, cmd_abort, cmd_seed, lfsr_word, lfsr_valid, req,
        output busy, done, issued, lfsr_rst_n, lfsr_start, lfsr_seed,
               gnt, gnt_data, dbg_state
    );

    modport slave (
        output cmd_start, cmd_abort, cmd_seed, lfsr_word, lfsr_valid, req,
        input  busy, done, issued, lfsr_rst_n, lfsr_start, lfsr_seed,
               gnt, gnt_data, dbg_state
    );
endinterface

// File: rtl/lfsr_dispatch_ctrl.sv
// Seeds and kicks one shared plaintext LFSR, then hands its words out
// round-robin to requesting DES cores until NUM_WORDS have been delivered.
module lfsr_dispatch_ctrl #(
    parameter int          NUM_REQ   = 4,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_dispatch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NREQ_L = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_KICK = 3'd2,
        S_WAIT = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [63:0]        seed_q, seed_nxt;
    logic [CNT_W-1:0]   issued_q, issued_nxt, issued_inc;
    logic [PTR_W-1:0]   rr_ptr, ptr_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [63:0]        gnt_data_q, gnt_data_nxt;
    logic               busy_c;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W:0]     cand;

    // Search starts at rr_ptr and wraps, so the core after the last winner
    // has first claim on the next word.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NREQ_L) begin
                cand = cand - NREQ_L;
            end
            if (!pick_found && bus.req[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign busy_c     = (state == S_LOAD) || (state == S_KICK) ||
                        (state == S_WAIT) || (state == S_RUN);
    assign issued_inc = issued_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            seed_q     <= '0;
            issued_q   <= '0;
            rr_ptr     <= '0;
            gnt_q      <= '0;
            gnt_data_q <= '0;
        end else begin
            state      <= state_nxt;
            seed_q     <= seed_nxt;
            issued_q   <= issued_nxt;
            rr_ptr     <= ptr_nxt;
            gnt_q      <= gnt_nxt;
            gnt_data_q <= gnt_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        seed_nxt     = seed_q;
        issued_nxt   = issued_q;
        ptr_nxt      = rr_ptr;
        gnt_nxt      = '0;
        gnt_data_nxt = '0;
        // Abort beats everything while busy; a grant decided in the abort
        // cycle is dropped, the one registered on the previous edge stays.
        if (busy_c && bus.cmd_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.cmd_start) begin
                        seed_nxt   = bus.cmd_seed;
                        issued_nxt = '0;
                        state_nxt  = S_LOAD;
                    end
                end
                S_LOAD: state_nxt = S_KICK;
                S_KICK: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (bus.lfsr_valid) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    // The LFSR never stalls: with no requester the word is lost.
                    if (bus.lfsr_valid && pick_found) begin
                        gnt_nxt      = NUM_REQ'(1) << pick_idx;
                        gnt_data_nxt = bus.lfsr_word;
                        issued_nxt   = issued_inc;
                        ptr_nxt      = (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);
                        if (issued_inc == LAST_WORD) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = (state == S_DONE);
    assign bus.issued     = issued_q;
    assign bus.lfsr_rst_n = busy_c;
    assign bus.lfsr_start = (state == S_KICK);
    assign bus.lfsr_seed  = seed_q;
    assign bus.gnt        = gnt_q;
    assign bus.gnt_data   = gnt_data_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_lfsr_dispatch_ctrl.sv
// Bench for lfsr_dispatch_ctrl: behavioural LFSR responder, reference model of
// the dispatch rules, directed scenarios and a randomized soak.
module tb_lfsr_dispatch_ctrl;
  localparam int NUM_REQ   = 4;
  localparam int NUM_WORDS = 4;
  localparam int CNT_W     = 32;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_KICK = 2;
  localparam int P_WAIT = 3;
  localparam int P_RUN  = 4;
  localparam int P_DONE = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_dispatch_ctrl_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus();

  lfsr_dispatch_ctrl #(
    .NUM_REQ(NUM_REQ), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [NUM_REQ-1:0] exp_gnt_q[$];
  bit sb_on = 1'b0;

  // ---------------- LFSR responder ----------------
  logic [63:0] lf_st    = '0;
  logic        lf_arm   = 1'b0;
  logic        lf_valid = 1'b0;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  always @(posedge clk) begin
    if (!bus.lfsr_rst_n) begin
      lf_st    <= '0;
      lf_arm   <= 1'b0;
      lf_valid <= 1'b0;
    end else if (bus.lfsr_start) begin
      lf_st    <= bus.lfsr_seed;
      lf_arm   <= 1'b1;
      lf_valid <= 1'b0;
    end else if (lf_arm) begin
      lf_arm   <= 1'b0;
      lf_valid <= 1'b1;
    end else if (lf_valid) begin
      lf_st <= lfsr_step(lf_st);
    end
  end

  assign bus.lfsr_word  = lf_st;
  assign bus.lfsr_valid = lf_valid;

  // ---------------- reference model ----------------
  int                 m_phase = P_IDLE;
  logic [63:0]        m_seed  = '0;
  longint             m_issued = 0;
  int                 m_ptr   = 0;
  logic [NUM_REQ-1:0] m_gnt   = '0;
  logic [63:0]        m_gdata = '0;
  int                 m_win;

  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic bit m_busy(input int p);
    return p == P_LOAD || p == P_KICK || p == P_WAIT || p == P_RUN;
  endfunction

  always @(posedge clk) begin
    m_gnt   = '0;
    m_gdata = '0;
    if (rst) begin
      m_phase  = P_IDLE;
      m_seed   = '0;
      m_issued = 0;
      m_ptr    = 0;
    end else if (m_busy(m_phase) && bus.cmd_abort) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (bus.cmd_start) begin
          m_seed   = bus.cmd_seed;
          m_issued = 0;
          m_phase  = P_LOAD;
        end
        P_LOAD: m_phase = P_KICK;
        P_KICK: m_phase = P_WAIT;
        P_WAIT: if (lf_valid) m_phase = P_RUN;
        P_RUN: if (lf_valid && bus.req != '0) begin
          m_win        = rr_pick(m_ptr, bus.req);
          m_gnt[m_win] = 1'b1;
          m_gdata      = lf_st;
          m_issued     = m_issued + 1;
          m_ptr        = (m_win + 1) % NUM_REQ;
          if (m_issued == NUM_WORDS) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", bus.busy, m_busy(m_phase));
    check_eq("done", bus.done, m_phase == P_DONE);
    check_eq("issued", bus.issued, m_issued);
    check_eq("lfsr_rst_n", bus.lfsr_rst_n, m_busy(m_phase));
    check_eq("lfsr_start", bus.lfsr_start, m_phase == P_KICK);
    check_eq("lfsr_seed", bus.lfsr_seed, m_seed);
    check_eq("gnt", bus.gnt, m_gnt);
    check_eq("gnt_data", bus.gnt_data, m_gdata);
  endtask

  task automatic scoreboard();
    if (sb_on && bus.gnt != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_grant", bus.gnt, '0);
      end else begin
        check_eq("sb_data", bus.gnt_data, exp_q.pop_front());
        check_eq("sb_core", bus.gnt, exp_gnt_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    scoreboard();
  endtask

  task automatic expect_grant(input logic [63:0] data, input logic [NUM_REQ-1:0] g);
    exp_q.push_back(data);
    exp_gnt_q.push_back(g);
  endtask

  task automatic start_run(input logic [63:0] seed);
    bus.cmd_seed  = seed;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin
      tick();
      n++;
    end
    if (m_phase != p) check_eq("wait_phase_timeout", m_phase, p);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_reached", bus.done, 1'b1);
  endtask

  task automatic sb_drained(input string tag);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    exp_gnt_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.cmd_seed  = '0;
    bus.req       = '0;
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset_gnt", bus.gnt, '0);
    check_eq("reset_rst_n", bus.lfsr_rst_n, 1'b0);
    rst = 1'b0;
    tick();

    // Full request set: words 1,3,7,F to cores 0..3.
    sb_on = 1'b1;
    bus.req = 4'b1111;
    expect_grant(64'h1, 4'b0001); expect_grant(64'h3, 4'b0010);
    expect_grant(64'h7, 4'b0100); expect_grant(64'hF, 4'b1000);
    start_run(64'h0);
    wait_done(30);
    check_eq("s1_issued", bus.issued, 4);
    check_eq("s1_rst_n", bus.lfsr_rst_n, 1'b0);
    sb_drained("s1_left");
    tick();

    // Cores 0 and 2 only.
    bus.req = 4'b0101;
    expect_grant(64'h1, 4'b0001); expect_grant(64'h3, 4'b0100);
    expect_grant(64'h7, 4'b0001); expect_grant(64'hF, 4'b0100);
    start_run(64'h0);
    wait_done(30);
    sb_drained("s2_left");

    // Two words dropped before core 1 starts requesting.
    bus.req = '0;
    expect_grant(64'h7, 4'b0010); expect_grant(64'hF, 4'b0010);
    expect_grant(64'h1F, 4'b0010); expect_grant(64'h3F, 4'b0010);
    start_run(64'h0);
    wait_phase(P_RUN, 20);
    tick();
    tick();
    bus.req = 4'b0010;
    wait_done(30);
    check_eq("s3_issued", bus.issued, 4);
    sb_drained("s3_left");

    // Abort two cycles into RUN, then restart from word 1.
    bus.req = 4'b1111;
    expect_grant(64'h1, 4'b0100); expect_grant(64'h3, 4'b1000);
    start_run(64'h0);
    wait_phase(P_RUN, 20);
    tick();
    tick();
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    check_eq("s4_busy", bus.busy, 1'b0);
    check_eq("s4_done", bus.done, 1'b0);
    check_eq("s4_rst_n", bus.lfsr_rst_n, 1'b0);
    check_eq("s4_issued_hold", bus.issued, 2);
    sb_drained("s4a_left");
    expect_grant(64'h1, 4'b0001); expect_grant(64'h3, 4'b0010);
    expect_grant(64'h7, 4'b0100); expect_grant(64'hF, 4'b1000);
    start_run(64'h0);
    wait_done(30);
    sb_drained("s4b_left");

    // Start while busy is ignored.
    expect_grant(64'h1, 4'b0001); expect_grant(64'h3, 4'b0010);
    expect_grant(64'h7, 4'b0100); expect_grant(64'hF, 4'b1000);
    start_run(64'h0);
    wait_phase(P_RUN, 20);
    tick();
    bus.cmd_seed  = 64'hDEAD_BEEF_0123_4567;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    check_eq("s5_seed_kept", bus.lfsr_seed, 64'h0);
    wait_done(30);
    sb_drained("s5_left");
    sb_on = 1'b0;

    // Reset in WAIT and in RUN.
    start_run(64'h0);
    wait_phase(P_WAIT, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s6_wait_busy", bus.busy, 1'b0);
    check_eq("s6_wait_issued", bus.issued, 0);
    repeat (6) tick();
    start_run(64'h5);
    wait_phase(P_RUN, 20);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s6_run_gnt", bus.gnt, '0);
    check_eq("s6_run_seed", bus.lfsr_seed, 64'h0);
    repeat (6) tick();

    // Randomized soak against the reference model.
    for (int run = 0; run < 40; run++) begin
      start_run({$urandom(), $urandom()});
      for (int c = 0; c < 30; c++) begin
        bus.req = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom_range(0, 15));
        bus.cmd_abort = ($urandom_range(0, 40) == 0);
        bus.cmd_start = ($urandom_range(0, 15) == 0);
        bus.cmd_seed  = {$urandom(), $urandom()};
        rst = ($urandom_range(0, 80) == 0);
        tick();
        bus.cmd_abort = 1'b0;
        bus.cmd_start = 1'b0;
        rst = 1'b0;
      end
    end
    bus.req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
